bus_initiator: RTL
==================

Name: bus_initiator

Overview:
- Sequences single read/write cycles onto the PET-clone system bus: drives address, rw_b, write data and a data strobe with fixed, parameterised timing.
- Feeds the registered address decoder and its chip selects; that decoder needs address setup before chip selects are valid.
- Requests arrive over a valid/ready handshake from the MCU bridge or test master. One cycle is in flight at a time, and completion is reported by a one-cycle response pulse.

Parameters:
- SETUP_CYCLES, 2: cycles address/rw_b/write data are held stable before strobe. Must be at least 1; covers the registered decoder latency.
- STROBE_CYCLES, 3: cycles bus_strobe is high. Must be at least 1.
- HOLD_CYCLES, 1: cycles address/rw_b/write data are held after strobe falls. May be 0.
- All three are at most 15 (4-bit phase counter).

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; the handshake fires when req_valid and req_ready are both high
- req_addr  in  17  target address (bit 16 selects the upper 64K)
- req_rw_b  in  1  1 = read, 0 = write
- req_wr_data  in  8  write data
- resp_valid  out  1  one-cycle completion pulse; no backpressure
- resp_rd_data  out  8  read data; valid when resp_valid is high, held until the next read completes
- bus_addr  out  17  bus address
- bus_rw_b  out  1  bus direction, 1 = read
- bus_data_out  out  8  bus write data
- bus_data_oe  out  1  write-data drive enable
- bus_data_in  in  8  bus read data
- bus_strobe  out  1  data strobe
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: bus_addr=0, bus_rw_b=1, bus_data_out=0, bus_data_oe=0, bus_strobe=0, req_ready=1, resp_valid=0, resp_rd_data=0, busy=0. State goes to IDLE and the counter clears.
- Reset is asynchronous and applies immediately, including mid-cycle. Strobe and oe drop without waiting for a clock edge, and no resp_valid is issued for the aborted request.
- All outputs are registered; no combinational path from req_* to bus_*.
- Machine states: IDLE, SETUP, STROBE, HOLD, RESP.
- IDLE:
  - req_ready=1.
  - On handshake: latch addr/rw_b/wr_data, load bus_addr/bus_rw_b/bus_data_out, set bus_data_oe = ~req_rw_b, go to SETUP with counter = SETUP_CYCLES-1.
  - With no handshake, bus_addr holds its last value and bus_rw_b returns to 1.
- SETUP: bus signals stable, strobe 0. Leave when the counter reaches 0, going to STROBE with counter = STROBE_CYCLES-1.
- STROBE:
  - bus_strobe=1 for exactly STROBE_CYCLES cycles.
  - For reads, bus_data_in is sampled into resp_rd_data on the last strobe cycle.
  - On exit: go to HOLD if HOLD_CYCLES>0, otherwise straight to RESP.
- HOLD: strobe 0; address, rw_b, data and oe all held for HOLD_CYCLES cycles; then go to RESP.
- RESP:
  - resp_valid=1 for exactly one cycle; bus_data_oe=0; bus_rw_b=1.
  - Next state is IDLE. req_ready rises in the cycle after resp_valid.
- Latency: handshake at edge N gives resp_valid high during cycle N+SETUP+STROBE+HOLD+1. Defaults give 7.
- Throughput: one request per SETUP+STROBE+HOLD+2 cycles.
- Request inputs are ignored while busy. req_* may change freely after the handshake.
- Writes never modify resp_rd_data.
- bus_strobe is never high while bus_addr or bus_rw_b is changing.
- bus_data_oe is never high with bus_rw_b=1.

Test Plan:
1. Reset then idle: assert reset mid-clock → outputs reach reset values before the next edge; release → req_ready=1, busy=0, bus_strobe=0 indefinitely.
2. Read $E812 (PIA1), bus_data_in=$5A during strobe, defaults:
   - bus_addr=$0E812 and bus_rw_b=1 from cycle 1.
   - bus_strobe high cycles 3-5.
   - resp_valid only at cycle 7 with resp_rd_data=$5A.
   - bus_data_oe=0 throughout.
3. Write $8000 (VRAM) data $41: bus_data_out=$41 and bus_data_oe=1 over cycles 1-6, strobe cycles 3-5, resp_valid at cycle 7, resp_rd_data unchanged.
4. Back-to-back: req_valid held high with two queued requests ($1_0000 read, $7FFF write) → second handshake at cycle 8; no overlap of strobe; bus_addr=$10000 then $07FFF.
5. HOLD_CYCLES=0, SETUP_CYCLES=1, STROBE_CYCLES=1 build: read → strobe only cycle 2, resp_valid at cycle 3.
6. Reset asserted during STROBE of a write → strobe and oe fall immediately, no resp_valid; a fresh read of $E880 afterwards completes normally.

Source files
------------

// File: rtl/bus_initiator.sv
// Single-cycle bus initiator for the PET-clone system bus: runs one request
// through fixed setup / strobe / hold phases and reports completion.
module bus_initiator #(
    parameter int unsigned SETUP_CYCLES  = 2,
    parameter int unsigned STROBE_CYCLES = 3,
    parameter int unsigned HOLD_CYCLES   = 1
) (
    input  logic        clk,
    input  logic        reset,
    // Handshake: a request is taken on the rising edge where req_valid and
    // req_ready are both high; req_ready is high only while IDLE.
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [16:0] req_addr,
    input  logic        req_rw_b,
    input  logic [7:0]  req_wr_data,
    output logic        resp_valid,
    output logic [7:0]  resp_rd_data,
    output logic [16:0] bus_addr,
    output logic        bus_rw_b,
    output logic [7:0]  bus_data_out,
    output logic        bus_data_oe,
    input  logic [7:0]  bus_data_in,
    output logic        bus_strobe,
    output logic        busy,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    // Phase counters count down to zero, so each load is the phase length minus one.
    localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] HOLD_LOAD   = (HOLD_CYCLES > 0) ? 4'(HOLD_CYCLES - 1) : 4'd0;
    localparam bit         HAS_HOLD    = (HOLD_CYCLES > 0);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_req_ready;
    logic        r_resp_valid;
    logic [7:0]  r_resp_rd_data;
    logic [16:0] r_bus_addr;
    logic        r_bus_rw_b;
    logic [7:0]  r_bus_data_out;
    logic        r_bus_data_oe;
    logic        r_bus_strobe;
    logic        r_busy;

    logic        w_handshake;
    logic        w_cnt_zero;

    assign w_handshake = req_valid & r_req_ready;
    assign w_cnt_zero  = (r_cnt == 4'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_cnt          <= 4'd0;
            r_req_ready    <= 1'b1;
            r_resp_valid   <= 1'b0;
            r_resp_rd_data <= 8'h00;
            r_bus_addr     <= 17'h0_0000;
            r_bus_rw_b     <= 1'b1;
            r_bus_data_out <= 8'h00;
            r_bus_data_oe  <= 1'b0;
            r_bus_strobe   <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_handshake) begin
                        r_bus_addr     <= req_addr;
                        r_bus_rw_b     <= req_rw_b;
                        r_bus_data_out <= req_wr_data;
                        r_bus_data_oe  <= ~req_rw_b;
                        r_req_ready    <= 1'b0;
                        r_busy         <= 1'b1;
                        r_cnt          <= SETUP_LOAD;
                        r_state        <= ST_SETUP;
                    end else begin
                        r_bus_rw_b <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (w_cnt_zero) begin
                        r_bus_strobe <= 1'b1;
                        r_cnt        <= STROBE_LOAD;
                        r_state      <= ST_STROBE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_STROBE: begin
                    if (w_cnt_zero) begin
                        r_bus_strobe <= 1'b0;
                        // Read data is captured on the final strobe cycle only.
                        if (r_bus_rw_b) begin
                            r_resp_rd_data <= bus_data_in;
                        end
                        if (HAS_HOLD) begin
                            r_cnt   <= HOLD_LOAD;
                            r_state <= ST_HOLD;
                        end else begin
                            r_resp_valid  <= 1'b1;
                            r_bus_data_oe <= 1'b0;
                            r_bus_rw_b    <= 1'b1;
                            r_state       <= ST_RESP;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_HOLD: begin
                    if (w_cnt_zero) begin
                        r_resp_valid  <= 1'b1;
                        r_bus_data_oe <= 1'b0;
                        r_bus_rw_b    <= 1'b1;
                        r_state       <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready    = r_req_ready;
    assign resp_valid   = r_resp_valid;
    assign resp_rd_data = r_resp_rd_data;
    assign bus_addr     = r_bus_addr;
    assign bus_rw_b     = r_bus_rw_b;
    assign bus_data_out = r_bus_data_out;
    assign bus_data_oe  = r_bus_data_oe;
    assign bus_strobe   = r_bus_strobe;
    assign busy         = r_busy;
    assign dbg_state    = r_state;

endmodule
